// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the writeback arbiter and its scoreboard.
package rv32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // Width of the LU starvation age counter; covers MAX_WAIT up to 15.
  localparam int AGE_W = 4;

  // Source granted the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_PIPE,
    WB_LU
  } wb_src_t;

  // One-hot register vector with only bit rd set.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rv32_wb_scoreboard.sv
// Tracks destination registers whose long-latency result has not yet been
// written back. x0 is never marked pending.
module rv32_wb_scoreboard
  import rv32_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_rd_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  output logic [NUM_REGS-1:0]   pending_mask_o
);

  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [NUM_REGS-1:0] set_vec, clr_vec;

  // Clear first, then set, so a same-cycle issue to the retiring register keeps it pending.
  always_comb begin
    set_vec   = set_en_i ? reg_onehot(set_rd_i) : '0;
    clr_vec   = clr_en_i ? reg_onehot(clr_rd_i) : '0;
    mask_d    = (mask_q & ~clr_vec) | set_vec;
    mask_d[0] = 1'b0;
  end

  // Pending-mask register.
  always_ff @(posedge clk) begin
    if (reset) mask_q <= '0;
    else       mask_q <= mask_d;
  end

  assign pending_mask_o = mask_q;

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback versus
// out-of-band long-latency (mul/div) results held in a one-entry skid buffer.
// The pipeline normally wins; a buffered result that has lost MAX_WAIT times
// is forced through and stalls the writeback stage if it had a request.
// After a buffer grant the buffer stays closed for one extra cycle (the cycle
// the write lands), so back-to-back LU results are spaced by one bubble.
module rv32_wb_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4  // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_in,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic                  pipe_rd_write,
  input  logic [XLEN-1:0]       pipe_rd_value,
  input  logic                  lu_issue,
  input  logic [REG_ADDR_W-1:0] lu_issue_rd,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic [XLEN-1:0]       lu_value,
  output logic                  lu_ready,
  output logic                  stall_out,
  output logic                  rf_write_en,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_value,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic                  waw_error
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic                  buf_valid_q, buf_valid_d;
  logic [REG_ADDR_W-1:0] buf_rd_q, buf_rd_d;
  logic [XLEN-1:0]       buf_value_q, buf_value_d;
  logic [AGE_W-1:0]      age_q, age_d;
  logic                  drain_q, drain_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]       rf_value_q, rf_value_d;
  logic                  waw_q, waw_d;

  logic    pipe_req;
  logic    buf_forced;
  logic    lu_accept;
  logic    grant_lu;
  wb_src_t src;

  assign pipe_req   = pipe_valid && pipe_rd_write && !flush_in && (pipe_rd != '0);
  assign buf_forced = buf_valid_q && (age_q == AGE_MAX);
  assign lu_ready   = !buf_valid_q && !drain_q;
  assign lu_accept  = lu_valid && lu_ready;
  assign grant_lu   = (src == WB_LU);

  // Grant decision: starving buffer first, then pipeline, then idle-port buffer drain.
  always_comb begin
    src       = WB_NONE;
    stall_out = 1'b0;
    if (buf_forced) begin
      src       = WB_LU;
      stall_out = pipe_req;
    end else if (pipe_req) begin
      src = WB_PIPE;
    end else if (buf_valid_q) begin
      src = WB_LU;
    end
  end

  // Next state of the write port, skid buffer, age counter and WAW flag.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_value_d = buf_value_q;
    age_d       = age_q;
    drain_d     = grant_lu;
    rf_we_d     = 1'b0;
    rf_rd_d     = rf_rd_q;
    rf_value_d  = rf_value_q;
    waw_d       = waw_q;

    case (src)
      WB_PIPE: begin
        rf_we_d    = 1'b1;
        rf_rd_d    = pipe_rd;
        rf_value_d = pipe_rd_value;
        if (pending_mask[pipe_rd]) waw_d = 1'b1;
      end
      WB_LU: begin
        rf_we_d    = (buf_rd_q != '0);
        rf_rd_d    = buf_rd_q;
        rf_value_d = buf_value_q;
      end
      default: ;
    endcase

    if (grant_lu) begin
      buf_valid_d = 1'b0;
      age_d       = '0;
    end else if (buf_valid_q && (age_q != AGE_MAX)) begin
      age_d = age_q + AGE_W'(1);
    end

    // lu_ready excludes a valid or draining buffer, so acceptance never overlaps a grant.
    if (lu_accept) begin
      buf_valid_d = 1'b1;
      buf_rd_d    = lu_rd;
      buf_value_d = lu_value;
      age_d       = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_value_q <= '0;
      age_q       <= '0;
      drain_q     <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_value_q  <= '0;
      waw_q       <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_value_q <= buf_value_d;
      age_q       <= age_d;
      drain_q     <= drain_d;
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_value_q  <= rf_value_d;
      waw_q       <= waw_d;
    end
  end

  rv32_wb_scoreboard u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .set_en_i       (lu_issue && (lu_issue_rd != '0)),
    .set_rd_i       (lu_issue_rd),
    .clr_en_i       (grant_lu),
    .clr_rd_i       (buf_rd_q),
    .pending_mask_o (pending_mask)
  );

  assign rf_write_en = rf_we_q;
  assign rf_rd       = rf_rd_q;
  assign rf_value    = rf_value_q;
  assign waw_error   = waw_q;

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Bench for rv32_wb_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a queue-based reference model.
module tb_rv32_wb_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset, flush_in, pipe_valid, pipe_rd_write, lu_issue, lu_valid;
  logic [4:0]  pipe_rd, lu_issue_rd, lu_rd;
  logic [31:0] pipe_rd_value, lu_value;
  logic        lu_ready, stall_out, rf_write_en, waw_error;
  logic [4:0]  rf_rd;
  logic [31:0] rf_value, pending_mask;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .flush_in(flush_in),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_rd_write(pipe_rd_write),
    .pipe_rd_value(pipe_rd_value),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_value(lu_value), .lu_ready(lu_ready),
    .stall_out(stall_out), .rf_write_en(rf_write_en), .rf_rd(rf_rd), .rf_value(rf_value),
    .pending_mask(pending_mask), .waw_error(waw_error)
  );

  typedef struct {
    logic        rst, flush, pv, pw;
    logic [4:0]  prd;
    logic [31:0] pval;
    logic        iss;
    logic [4:0]  ird;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lval;
    logic        rdy, stl, we, dchk;
    logic [4:0]  rd;
    logic [31:0] val, pend;
    logic        waw;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } lu_ent_t;

  function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pval,
                              input logic iss, input logic [4:0] ird,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] lval,
                              input logic rdy, input logic stl,
                              input logic we, input logic [4:0] rd, input logic [31:0] val,
                              input logic [31:0] pend, input logic waw);
    vec_t t;
    t.rst = 1'b0; t.flush = 1'b0; t.pv = pv; t.pw = pv; t.prd = prd; t.pval = pval;
    t.iss = iss; t.ird = ird; t.lv = lv; t.lrd = lrd; t.lval = lval;
    t.rdy = rdy; t.stl = stl; t.we = we; t.dchk = 1'b0; t.rd = rd; t.val = val;
    t.pend = pend; t.waw = waw;
    return t;
  endfunction

  function automatic vec_t idle(input logic rdy, input logic [31:0] pend, input logic waw);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, rdy, 0, 0, 0, 0, pend, waw);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    reset = t.rst; flush_in = t.flush;
    pipe_valid = t.pv; pipe_rd_write = t.pw; pipe_rd = t.prd; pipe_rd_value = t.pval;
    lu_issue = t.iss; lu_issue_rd = t.ird;
    lu_valid = t.lv; lu_rd = t.lrd; lu_value = t.lval;
  endtask

  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    drive(t);
    #1;
    chk({tag, " lu_ready"}, lu_ready, t.rdy);
    chk({tag, " stall_out"}, stall_out, t.stl);
    @(posedge clk);
    #1;
    chk({tag, " rf_write_en"}, rf_write_en, t.we);
    if (t.we || t.dchk) begin
      chk({tag, " rf_rd"}, rf_rd, t.rd);
      chk({tag, " rf_value"}, rf_value, t.val);
    end
    chk({tag, " pending_mask"}, pending_mask, t.pend);
    chk({tag, " waw_error"}, waw_error, t.waw);
  endtask

  // Reference model state: buffer as a queue of at most one entry.
  lu_ent_t     m_buf[$];
  int          m_age;
  bit          m_bubble, m_waw, m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_val;
  bit   [31:0] m_pend;

  task automatic model_reset();
    m_buf.delete();
    m_age = 0; m_bubble = 0; m_waw = 0; m_we = 0; m_rd = 0; m_val = 0; m_pend = 0;
  endtask

  task automatic run_random(input int cycles);
    vec_t    t;
    bit      p_hold, l_hold, req, has, rdy, stl;
    int      src;
    lu_ent_t e;
    bit [31:0] pn;
    p_hold = 0; l_hold = 0;
    t = idle(1, 0, 0);
    for (int c = 0; c < cycles; c++) begin
      t.rst = ($urandom_range(0, 199) == 0);
      if (!p_hold) begin
        t.pv    = ($urandom_range(0, 3) != 0);
        t.pw    = ($urandom_range(0, 7) != 0);
        t.flush = ($urandom_range(0, 9) == 0);
        t.prd   = 5'($urandom_range(0, 7));
        t.pval  = $urandom;
      end
      if (!l_hold) begin
        t.lv   = ($urandom_range(0, 2) == 0);
        t.lrd  = 5'($urandom_range(0, 7));
        t.lval = $urandom;
      end
      t.iss = ($urandom_range(0, 3) == 0);
      t.ird = 5'($urandom_range(0, 7));

      req = t.pv && t.pw && !t.flush && (t.prd != 0);
      has = (m_buf.size() != 0);
      rdy = !has && !m_bubble;
      stl = 0;
      if (has && m_age == MAX_WAIT) begin src = 2; stl = req; end
      else if (req)                 src = 1;
      else if (has)                 src = 2;
      else                          src = 0;

      @(negedge clk);
      drive(t);
      #1;
      chk($sformatf("rnd%0d lu_ready", c), lu_ready, rdy);
      chk($sformatf("rnd%0d stall_out", c), stall_out, stl);

      if (t.rst) begin
        model_reset();
      end else begin
        pn = m_pend;
        if (src == 2) begin
          e = m_buf.pop_front();
          m_we = (e.rd != 0); m_rd = e.rd; m_val = e.val;
          m_age = 0; m_bubble = 1; pn[e.rd] = 0;
        end else begin
          m_bubble = 0;
          if (src == 1) begin
            m_we = 1; m_rd = t.prd; m_val = t.pval;
            if (m_pend[t.prd]) m_waw = 1;
          end else begin
            m_we = 0;
          end
          if (has && m_age < MAX_WAIT) m_age++;
        end
        if (t.iss && t.ird != 0) pn[t.ird] = 1;
        m_pend = pn;
        if (t.lv && rdy) begin
          e.rd = t.lrd; e.val = t.lval;
          m_buf.push_back(e);
          m_age = 0;
        end
      end
      p_hold = stl;
      l_hold = t.lv && !rdy;

      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d rf_write_en", c), rf_write_en, m_we);
      if (m_we) begin
        chk($sformatf("rnd%0d rf_rd", c), rf_rd, m_rd);
        chk($sformatf("rnd%0d rf_value", c), rf_value, m_val);
      end
      chk($sformatf("rnd%0d pending_mask", c), pending_mask, m_pend);
      chk($sformatf("rnd%0d waw_error", c), waw_error, m_waw);
    end
  endtask

  vec_t tbl[$];
  vec_t t;

  initial begin
    drive(idle(1, 0, 0));
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state.
    t = idle(1, 0, 0); t.rst = 1; t.dchk = 1; tbl.push_back(t);
    // Pipeline only.
    tbl.push_back(mk(1, 5, 'h1234, 0, 0, 0, 0, 0, 1, 0, 1, 5, 'h1234, 0, 0));
    tbl.push_back(idle(1, 0, 0));
    // LU result on an idle port: accept, grant, write, bubble, ready again.
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 7, 'hDEAD, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 'hDEAD, 0, 0));
    tbl.push_back(idle(0, 0, 0));
    tbl.push_back(idle(1, 0, 0));
    // Flush, x0 and no-write requests are ignored.
    t = mk(1, 6, 'h55, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); t.flush = 1; tbl.push_back(t);
    tbl.push_back(mk(1, 0, 'h66, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    t = mk(1, 8, 'h88, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); t.pw = 0; tbl.push_back(t);
    // Scoreboard set, WAW while pending, set-wins, clear after grant.
    tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 'h8, 0));
    tbl.push_back(mk(1, 3, 'h77, 0, 0, 0, 0, 0, 1, 0, 1, 3, 'h77, 'h8, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 'hC3, 1, 0, 0, 0, 0, 'h8, 1));
    tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 3, 'hC3, 'h8, 1));
    tbl.push_back(idle(0, 'h8, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 'hC4, 1, 0, 0, 0, 0, 'h8, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'hC4, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    // Buffered x0 result is granted without a write.
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 'hEE, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(1, 0, 1));
    // Pipeline beats a fresh buffer; buffer drains on the first idle cycle.
    tbl.push_back(mk(1, 11, 'hB0, 0, 0, 1, 10, 'hA0, 1, 0, 1, 11, 'hB0, 0, 1));
    tbl.push_back(mk(1, 12, 'hB1, 0, 0, 0, 0, 0, 0, 0, 1, 12, 'hB1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 'hA0, 0, 1));
    tbl.push_back(idle(0, 0, 1));
    tbl.push_back(idle(1, 0, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Starvation with a held pipeline instruction.
    apply(mk(0, 0, 0, 0, 0, 1, 9, 'h99, 1, 0, 0, 0, 0, 0, 1), "starve acc");
    for (int i = 1; i <= 4; i++)
      apply(mk(1, 5'(20 + i), 32'h100 + i, 0, 0, 0, 0, 0, 0, 0, 1, 5'(20 + i), 32'h100 + i, 0, 1),
            $sformatf("starve pipe%0d", i));
    apply(mk(1, 25, 'h125, 0, 0, 0, 0, 0, 0, 1, 1, 9, 'h99, 0, 1), "starve forced");
    apply(mk(1, 25, 'h125, 0, 0, 0, 0, 0, 0, 0, 1, 25, 'h125, 0, 1), "starve replay");
    apply(idle(1, 0, 1), "starve done");

    // Forced grant with no pipeline request does not stall.
    apply(mk(0, 0, 0, 0, 0, 1, 9, 'h9A, 1, 0, 0, 0, 0, 0, 1), "force acc");
    for (int i = 1; i <= 4; i++)
      apply(mk(1, 5'(20 + i), 32'h200 + i, 0, 0, 0, 0, 0, 0, 0, 1, 5'(20 + i), 32'h200 + i, 0, 1),
            $sformatf("force pipe%0d", i));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h9A, 0, 1), "force idle");
    apply(idle(0, 0, 1), "force bubble");
    apply(idle(1, 0, 1), "force done");

    // Reset with a full buffer and a pending register.
    apply(mk(1, 1, 'h11, 1, 3, 0, 0, 0, 1, 0, 1, 1, 'h11, 'h8, 1), "rst issue");
    apply(mk(1, 2, 'h22, 0, 0, 1, 3, 'hAB, 1, 0, 1, 2, 'h22, 'h8, 1), "rst fill");
    t = mk(1, 4, 'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); t.rst = 1; t.dchk = 1;
    apply(t, "rst assert");
    t = idle(1, 0, 0); t.dchk = 1;
    apply(t, "rst after1");
    apply(t, "rst after2");

    // Randomized traffic from a clean reset.
    t = idle(1, 0, 0); t.rst = 1; t.dchk = 1;
    apply(t, "rnd reset");
    model_reset();
    run_random(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
